// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-stage SRAM controller.
// Each 32-bit load or store becomes two 16-bit accesses (low half, then high
// half) on an external asynchronous SRAM. Every half-word access takes
// WAIT_CYCLES cycles. While a transfer is in flight, ready is low so that the
// upstream pipeline registers stay frozen and hold the request inputs stable.
module mem_sram_ctrl #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Terminal value of the per-half-word wait counter.
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 32'd1);
  localparam logic [31:0] BASE     = 32'(ADDR_BASE);

  // Word index of a byte address after removing the SRAM base offset. The
  // subtraction wraps modulo 2^32, and the two byte-offset bits are dropped,
  // so a misaligned address is silently aligned to its word.
  function automatic logic [16:0] word_index(input logic [31:0] addr);
    return 17'((addr - BASE) >> 2);
  endfunction

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] rdata_r;
  logic [17:0] sram_addr_r;
  logic        sram_we_n_r;
  logic [15:0] sram_dq_out_r;
  logic        sram_dq_oe_r;

  logic        req_s;
  logic        store_s;
  logic        last_s;
  logic [16:0] w_s;

  // Decode the request, the target word, and the terminal count.
  always_comb begin
    req_s   = mem_r_en | mem_w_en;
    store_s = mem_w_en;              // a store wins when both enables are set
    w_s     = word_index(alu_result);
    last_s  = (cnt_r == LAST_CNT);
  end

  // The hazard unit needs ready in the same cycle the request appears, so it
  // stays combinational. In DONE it rises for exactly one cycle. When the
  // enables drop mid-access it also reads high.
  assign ready = ~req_s | (state_r == DONE);

  assign rdata       = rdata_r;
  assign sram_addr   = sram_addr_r;
  assign sram_we_n   = sram_we_n_r;
  assign sram_dq_out = sram_dq_out_r;
  assign sram_dq_oe  = sram_dq_oe_r;

  // Transfer sequencer. It owns the state, the wait counter, the captured
  // read data, and all SRAM-side outputs. Those outputs are registered and
  // are loaded together with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      rdata_r       <= 32'd0;
      sram_addr_r   <= 18'd0;
      sram_we_n_r   <= 1'b1;
      sram_dq_out_r <= 16'd0;
      sram_dq_oe_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 4'd0;
          if (req_s) begin
            sram_addr_r <= {w_s, 1'b0};
            if (store_s) begin
              state_r       <= WR_LO;
              sram_we_n_r   <= 1'b0;
              sram_dq_oe_r  <= 1'b1;
              sram_dq_out_r <= st_val[15:0];
            end else begin
              state_r       <= RD_LO;
              sram_we_n_r   <= 1'b1;
              sram_dq_oe_r  <= 1'b0;
              sram_dq_out_r <= 16'd0;
            end
          end else begin
            state_r       <= IDLE;
            sram_addr_r   <= 18'd0;
            sram_we_n_r   <= 1'b1;
            sram_dq_oe_r  <= 1'b0;
            sram_dq_out_r <= 16'd0;
          end
        end

        RD_LO: begin
          if (last_s) begin
            cnt_r          <= 4'd0;
            rdata_r[15:0]  <= sram_dq_in;
            sram_addr_r    <= {sram_addr_r[17:1], 1'b1};
            state_r        <= RD_HI;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end

        RD_HI: begin
          if (last_s) begin
            cnt_r          <= 4'd0;
            rdata_r[31:16] <= sram_dq_in;
            sram_addr_r    <= 18'd0;
            state_r        <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end

        WR_LO: begin
          if (last_s) begin
            cnt_r         <= 4'd0;
            sram_addr_r   <= {sram_addr_r[17:1], 1'b1};
            sram_dq_out_r <= st_val[31:16];
            state_r       <= WR_HI;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end

        WR_HI: begin
          if (last_s) begin
            cnt_r         <= 4'd0;
            sram_addr_r   <= 18'd0;
            sram_we_n_r   <= 1'b1;
            sram_dq_oe_r  <= 1'b0;
            sram_dq_out_r <= 16'd0;
            state_r       <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end

        DONE: begin
          // Leave unconditionally, so the request that just completed can
          // never start a second transfer. A new request is seen in IDLE.
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end

        default: begin
          cnt_r         <= 4'd0;
          sram_addr_r   <= 18'd0;
          sram_we_n_r   <= 1'b1;
          sram_dq_oe_r  <= 1'b0;
          sram_dq_out_r <= 16'd0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl.
// Two instances are used: the default WAIT_CYCLES=5 and WAIT_CYCLES=1. The
// bench drives one of them at a time. A word-level reference model predicts
// every cycle of a transfer from its position within the transfer.
module tb_mem_sram_ctrl;

  localparam int          WAIT = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;          // 0: default instance, 1: WAIT_CYCLES=1 instance
  logic        r_en, w_en;
  logic [31:0] alu, st;
  logic [15:0] dq_in;

  logic        ready0, we_n0, oe0, ready1, we_n1, oe1;
  logic [31:0] rdata0, rdata1;
  logic [17:0] addr0, addr1;
  logic [15:0] dq_out0, dq_out1;

  logic        cur_ready, cur_we_n, cur_oe;
  logic [31:0] cur_rdata;
  logic [17:0] cur_addr;
  logic [15:0] cur_dq_out;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] ref_word [int];
  logic [31:0] exp_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(5)) dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en & ~sel), .mem_w_en(w_en & ~sel),
    .alu_result(alu), .st_val(st), .ready(ready0), .rdata(rdata0),
    .sram_addr(addr0), .sram_we_n(we_n0), .sram_dq_out(dq_out0),
    .sram_dq_oe(oe0), .sram_dq_in(dq_in));

  mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en & sel), .mem_w_en(w_en & sel),
    .alu_result(alu), .st_val(st), .ready(ready1), .rdata(rdata1),
    .sram_addr(addr1), .sram_we_n(we_n1), .sram_dq_out(dq_out1),
    .sram_dq_oe(oe1), .sram_dq_in(dq_in));

  always_comb begin
    cur_ready  = sel ? ready1  : ready0;
    cur_we_n   = sel ? we_n1   : we_n0;
    cur_oe     = sel ? oe1     : oe0;
    cur_rdata  = sel ? rdata1  : rdata0;
    cur_addr   = sel ? addr1   : addr0;
    cur_dq_out = sel ? dq_out1 : dq_out0;
  end

  // Asynchronous SRAM model: reads are combinational, writes happen while we_n is low.
  assign dq_in = sram_mem[cur_addr];
  always @(negedge clk) if (!cur_we_n) sram_mem[cur_addr] <= cur_dq_out;

  // One complete transfer, checked cycle by cycle. Cycle 0 is the request
  // seen in IDLE, cycles 1..W are the low half, W+1..2W are the high half,
  // and cycle 2W+1 is the completion cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int          wc, last;
    logic [16:0] w;
    logic [17:0] lo, hi, e_addr;
    logic [15:0] e_dq;
    logic [31:0] exp_rd;
    logic        e_ready, e_we_n;
    wc   = sel ? 1 : WAIT;
    last = 2 * wc + 1;
    w    = 17'((addr - BASE) >> 2);
    lo   = {w, 1'b0};
    hi   = {w, 1'b1};
    if (wr) exp_rd = exp_rdata;
    else    exp_rd = ref_word.exists(int'(w)) ? ref_word[int'(w)] : 32'd0;
    @(posedge clk); #1;
    r_en = rd; w_en = wr; alu = addr; st = data;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      e_ready = (k == last);
      e_we_n  = !(wr && k >= 1 && k <= 2 * wc);
      if (k >= 1 && k <= wc)          e_addr = lo;
      else if (k > wc && k <= 2 * wc) e_addr = hi;
      else                            e_addr = 18'd0;
      if (wr && k >= 1 && k <= wc)           e_dq = data[15:0];
      else if (wr && k > wc && k <= 2 * wc)  e_dq = data[31:16];
      else                                   e_dq = 16'd0;
      n_checks++;
      if (cur_ready !== e_ready) $display("FAIL ready a=%h k=%0d got %b exp %b", addr, k, cur_ready, e_ready);
      else n_pass++;
      n_checks++;
      if (cur_we_n !== e_we_n) $display("FAIL we_n a=%h k=%0d got %b exp %b", addr, k, cur_we_n, e_we_n);
      else n_pass++;
      n_checks++;
      if (cur_oe !== !e_we_n) $display("FAIL dq_oe a=%h k=%0d got %b exp %b", addr, k, cur_oe, !e_we_n);
      else n_pass++;
      n_checks++;
      if (cur_addr !== e_addr) $display("FAIL sram_addr a=%h k=%0d got %h exp %h", addr, k, cur_addr, e_addr);
      else n_pass++;
      n_checks++;
      if (cur_dq_out !== e_dq) $display("FAIL dq_out a=%h k=%0d got %h exp %h", addr, k, cur_dq_out, e_dq);
      else n_pass++;
      if (k == last) begin
        n_checks++;
        if (cur_rdata !== exp_rd) $display("FAIL rdata a=%h got %h exp %h", addr, cur_rdata, exp_rd);
        else n_pass++;
      end
    end
    if (wr) ref_word[int'(w)] = data;
    exp_rdata = exp_rd;
  endtask

  // Drop the request and confirm the controller rests idle.
  task automatic idle_gap(input int n);
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (cur_ready !== 1'b1 || cur_we_n !== 1'b1 || cur_oe !== 1'b0 || cur_addr !== 18'd0)
        $display("FAIL idle_gap cyc=%0d got rdy=%b we_n=%b oe=%b addr=%h exp 1 1 0 0", i, cur_ready, cur_we_n, cur_oe, cur_addr);
      else n_pass++;
      if (i < n - 1) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; r_en = 1'b0; w_en = 1'b0; alu = 32'd0; st = 32'd0;
    #3;
    n_checks++;
    if (cur_ready !== 1'b1 || cur_we_n !== 1'b1 || cur_oe !== 1'b0 || cur_addr !== 18'd0 ||
        cur_dq_out !== 16'd0 || cur_rdata !== 32'd0)
      $display("FAIL reset_values got rdy=%b we_n=%b oe=%b addr=%h dq=%h rdata=%h exp 1 1 0 0 0 0",
               cur_ready, cur_we_n, cur_oe, cur_addr, cur_dq_out, cur_rdata);
    else n_pass++;
    r_en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cur_ready !== 1'b0 || cur_addr !== 18'd0)
      $display("FAIL reset_req_ready got rdy=%b addr=%h exp 0 0", cur_ready, cur_addr);
    else n_pass++;
    r_en = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle();
    idle_gap(20);
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, BASE + 32'd8, 32'hDEADBEEF);
    idle_gap(2);
  endtask

  task automatic test_load();
    run_txn(1'b1, 1'b0, 32'd1032, 32'd0);
    idle_gap(2);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 32'd1032, 32'd0);
    run_txn(1'b0, 1'b1, 32'd1036, 32'h12345678);
    run_txn(1'b1, 1'b0, 32'd1036, 32'd0);
    idle_gap(2);
  endtask

  // Wrapped addresses below the base, and misaligned byte offsets.
  task automatic test_boundary();
    run_txn(1'b0, 1'b1, 32'd0, 32'hA5A55A5A);
    run_txn(1'b1, 1'b0, 32'd3, 32'd0);
    run_txn(1'b0, 1'b1, BASE + 32'd23, 32'h0F0FF0F0);
    run_txn(1'b1, 1'b0, BASE + 32'd20, 32'd0);
    idle_gap(1);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit          wr;
    for (int i = 0; i < 30; i++) begin
      a  = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      d  = $urandom;
      wr = ($urandom_range(0, 1) == 1);
      run_txn(!wr || ($urandom_range(0, 1) == 1), wr, a, d);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
    end
    idle_gap(1);
  endtask

  task automatic test_reset_mid_store();
    run_txn(1'b1, 1'b0, 32'd1032, 32'd0);       // leave a non-zero rdata behind
    @(posedge clk); #1;
    w_en = 1'b1; r_en = 1'b0; alu = BASE + 32'h4000; st = 32'hCAFEF00D;
    repeat (WAIT + 2) @(posedge clk);            // now inside the high half
    #2;
    n_checks++;
    if (cur_we_n !== 1'b0 || cur_addr !== 18'h2001)
      $display("FAIL pre_reset_wr_hi got we_n=%b addr=%h exp 0 2001", cur_we_n, cur_addr);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cur_we_n !== 1'b1 || cur_oe !== 1'b0 || cur_addr !== 18'd0 || cur_rdata !== 32'd0 || cur_ready !== 1'b0)
      $display("FAIL reset_mid_store got we_n=%b oe=%b addr=%h rdata=%h rdy=%b exp 1 0 0 0 0",
               cur_we_n, cur_oe, cur_addr, cur_rdata, cur_ready);
    else n_pass++;
    w_en = 1'b0;
    #1;
    n_checks++;
    if (cur_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", cur_ready);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    exp_rdata = 32'd0;
    idle_gap(3);
  endtask

  task automatic test_both_enables();
    sel = 1'b1;
    idle_gap(1);
    run_txn(1'b1, 1'b1, BASE + 32'd64, 32'h89ABCDEF);
    run_txn(1'b1, 1'b0, BASE + 32'd64, 32'd0);
    run_txn(1'b1, 1'b0, 32'd1032, 32'd0);
    idle_gap(2);
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'd0;
    exp_rdata = 32'd0;
    test_reset();
    test_idle();
    test_store();
    test_load();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_mid_store();
    test_both_enables();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Memory-stage SRAM controller for the ARM pipeline. It consumes the EX→MEM pipeline register outputs (read/write enables, ALU address, store value) and runs each 32-bit load or store as two 16-bit accesses on an external asynchronous SRAM. While an access is in progress it drives `ready` low, and the hazard/freeze logic uses that to hold the upstream pipeline registers. Read data is presented to the MEM/WB register.

## Interface
- `ADDR_BASE`, default 1024: byte offset subtracted from the ALU address before mapping onto the SRAM.
- `WAIT_CYCLES`, default 5: cycles spent per 16-bit half-word access. Legal range is 1..15.
- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_en`  in  1  load request from the EX→MEM register.
- `mem_w_en`  in  1  store request from the EX→MEM register.
- `alu_result`  in  32  byte address of the access.
- `st_val`  in  32  store data.
- `ready`  out  1  high when no access is pending or the current access completes this cycle; low means freeze the pipeline.
- `rdata`  out  32  last loaded word.
- `sram_addr`  out  18  half-word address to the SRAM.
- `sram_we_n`  out  1  SRAM write enable, active low.
- `sram_dq_out`  out  16  write data to the SRAM.
- `sram_dq_oe`  out  1  output enable for the top-level tristate driving the SRAM DQ bus.
- `sram_dq_in`  in  16  read data from the SRAM DQ bus.

## Operation
**Request and address mapping**
- `req = mem_r_en | mem_w_en`. If both are asserted, the store wins.
- `eff = alu_result - ADDR_BASE`, computed as 32-bit unsigned arithmetic with wrap-around.
- Word index `w = eff[18:2]`. `eff[1:0]` is ignored; misaligned accesses are silently aligned.
- The low half-word lives at `{w,1'b0}` and the high half-word at `{w,1'b1}`.

**States:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE: if `req`, go to WR_LO on a store or RD_LO on a load. Otherwise stay in IDLE.
- RD_LO / WR_LO: a 4-bit counter `cnt` runs 0..WAIT_CYCLES-1. At `cnt == WAIT_CYCLES-1`, clear `cnt` and advance to RD_HI / WR_HI.
- RD_HI / WR_HI: same counting. At terminal count, go to DONE.
- DONE: go to IDLE unconditionally. A back-to-back request is therefore detected in IDLE on the following cycle, and the same request can never be retriggered.

**Output rules**
- `ready = ~req | (state == DONE)`. This is combinational.
- `sram_addr` is `{w,0}` in the \*_LO states and `{w,1}` in the \*_HI states. In IDLE and DONE it is 0.
- `sram_we_n = 0` only in WR_LO/WR_HI. `sram_dq_oe = 1` only in WR_LO/WR_HI.
- `sram_dq_out` is `st_val[15:0]` in WR_LO, `st_val[31:16]` in WR_HI, and 0 otherwise.
- Read capture happens at terminal count: RD_LO loads `rdata[15:0]` from `sram_dq_in`, and RD_HI loads `rdata[31:16]`.
- `rdata` holds its value until the next load overwrites it. Stores never modify it.

**Input stability:** the inputs are held stable while `ready` is low, because upstream is frozen. The controller does not latch them.

## Timing
- **Reset values:**
  - state = IDLE, `cnt` = 0, `rdata` = 0.
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `ready` = `~req`.
- **Latency (load or store):**
  - cycle 0: request seen in IDLE.
  - cycles 1..WAIT_CYCLES: LO half-word.
  - cycles WAIT_CYCLES+1..2·WAIT_CYCLES: HI half-word.
  - cycle 2·WAIT_CYCLES+1: DONE, with `ready` high.
  - `ready` is low for 2·WAIT_CYCLES+1 cycles, so the total is 2·WAIT_CYCLES+2 cycles (12 at the default).
  - `rdata` is valid in the DONE cycle.
- **No request:** `ready` stays high and the state stays IDLE, with zero added latency.
- **WAIT_CYCLES = 1:** each half-word state lasts exactly one cycle, giving a total of 4 cycles.
- **Reset mid-access:** the state machine aborts immediately to IDLE. `sram_we_n` deasserts asynchronously, a partial `rdata` is cleared, and no DONE pulse is produced.
- **Enable dropped mid-access:** this cannot happen in legal use. If it does, the state machine still completes the access, but `ready` reads 1 throughout.

## Test plan
1. **Idle:** with `mem_r_en = mem_w_en = 0` for 20 cycles:
   - `ready` = 1 and `sram_we_n` = 1 throughout.
   - `sram_dq_oe` = 0 throughout.
2. **Store:** `mem_w_en = 1`, `alu_result = 1024+8`, `st_val = 0xDEADBEEF`, WAIT_CYCLES = 5.
   - `sram_addr` = 4 with `dq_out` = 0xBEEF for 5 cycles, then `sram_addr` = 5 with `dq_out` = 0xDEAD for 5 cycles.
   - `we_n` is low for 10 cycles.
   - `ready` is low for 11 cycles and high on cycle 11.
3. **Load:** the SRAM model holds 0xBEEF at address 4 and 0xDEAD at address 5. Assert `mem_r_en` at `alu_result = 1032`.
   - `rdata` = 0xDEADBEEF in the DONE cycle.
   - `we_n` stays 1 and `oe` stays 0 throughout.
4. **Back-to-back:** a load at 1032 immediately followed by a store at 1036.
   - There is a single-cycle `ready` pulse between the two transfers.
   - The second transfer starts in IDLE on the next cycle, at `sram_addr` = 6/7.
   - `rdata` is unchanged by the store.
5. **Reset mid-store:** assert `rst` during WR_HI.
   - `we_n` = 1 immediately; state = IDLE; `rdata` = 0.
   - After release with `mem_w_en = 0`, `ready` = 1.
6. **Both enables and WAIT_CYCLES = 1:** assert `mem_r_en = mem_w_en = 1`.
   - A store is performed (`we_n` is low for 2 cycles).
   - `ready` is high on cycle 3.
